k6502_trace: RTL and testbench

//  Instruction-fetch trace buffer sitting directly downstream of the k6502 core bus.
//  On every opcode fetch (sync=1), captures the fetch address, opcode byte and a cycle timestamp.

---
 rtl/k6502_trace.sv | 104 ++++++++++
 tb/tb_k6502_trace.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/k6502_trace.sv
// Instruction-fetch trace FIFO for the k6502 core bus: captures {ts, addr, opcode} on sync.
// Optional address-window filter enabled by defining K6502_TRACE_FILTER_EN.
module k6502_trace #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef K6502_TRACE_FILTER_EN
  input  logic [15:0]              flt_lo,
  input  logic [15:0]              flt_hi,
  input  logic                     flt_inv,
`endif
  input  logic [15:0]              a,
  input  logic [7:0]               d,
  input  logic                     sync,
  input  logic                     clr,
  input  logic                     tr_ready,
  output logic                     tr_valid,
  output logic [15:0]              tr_addr,
  output logic [7:0]               tr_op,
  output logic [TS_W-1:0]          tr_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = TS_W + 24;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TS_W-1:0] ts;
  logic [EW-1:0]   head;
  logic            pass;
  logic            push;
  logic            pop;
  logic            full;
  logic            wr_en;

`ifdef K6502_TRACE_FILTER_EN
  // An inverted window (flt_lo > flt_hi) never matches, so pass falls back to flt_inv.
  always_comb begin
    pass = ((a >= flt_lo) && (a <= flt_hi)) ^ flt_inv;
  end
`else
  always_comb begin
    pass = 1'b1;
  end
`endif

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  always_comb begin
    full  = (level == FULL_LVL);
    pop   = tr_valid & tr_ready;
    push  = sync & pass;
    wr_en = push & (~full | pop);
  end

  always_comb begin
    tr_valid = (level != '0);
    head     = mem[rd_ptr];
    tr_ts    = tr_valid ? head[EW-1:24] : '0;
    tr_addr  = tr_valid ? head[23:8]    : '0;
    tr_op    = tr_valid ? head[7:0]     : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr] <= {ts, a, d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      level <= level + 1'b1;
      else if (pop && !wr_en) level <= level - 1'b1;
      if (push && full && !pop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_k6502_trace.sv
// Bench for k6502_trace: directed vector table plus model-checked overflow, wrap and filter sequences.
module tb_k6502_trace;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  d;
  logic        sync;
  logic        clr;
  logic        tr_ready;
  logic        tr_valid;
  logic [15:0] tr_addr;
  logic [7:0]  tr_op;
  logic [15:0] tr_ts;
  logic [4:0]  level;
  logic        ovf;
  logic [7:0]  drop_cnt;

  logic        s_valid;
  logic [15:0] s_addr;
  logic [7:0]  s_op;
  logic [3:0]  s_ts;
  logic [2:0]  s_level;
  logic        s_ovf;
  logic [7:0]  s_drop;

`ifdef K6502_TRACE_FILTER_EN
  logic [15:0] flt_lo;
  logic [15:0] flt_hi;
  logic        flt_inv;
`endif

  k6502_trace #(.DEPTH(16), .TS_W(16)) dut (
    .clk(clk), .rst(rst),
`ifdef K6502_TRACE_FILTER_EN
    .flt_lo(flt_lo), .flt_hi(flt_hi), .flt_inv(flt_inv),
`endif
    .a(a), .d(d), .sync(sync), .clr(clr), .tr_ready(tr_ready),
    .tr_valid(tr_valid), .tr_addr(tr_addr), .tr_op(tr_op), .tr_ts(tr_ts),
    .level(level), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  k6502_trace #(.DEPTH(4), .TS_W(4)) dut_small (
    .clk(clk), .rst(rst),
`ifdef K6502_TRACE_FILTER_EN
    .flt_lo(flt_lo), .flt_hi(flt_hi), .flt_inv(flt_inv),
`endif
    .a(a), .d(d), .sync(sync), .clr(clr), .tr_ready(tr_ready),
    .tr_valid(s_valid), .tr_addr(s_addr), .tr_op(s_op), .tr_ts(s_ts),
    .level(s_level), .ovf(s_ovf), .drop_cnt(s_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] tb_ts;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 16'd1;
  end

  typedef struct {
    logic [15:0] ts;
    logic [15:0] addr;
    logic [7:0]  op;
  } entry_t;

  typedef struct {
    logic        s;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rdy;
    logic        c;
    logic        v;
    logic [15:0] ea;
    logic [7:0]  eo;
    logic [15:0] et;
    logic [4:0]  lvl;
    logic        eovf;
    logic [7:0]  edrop;
  } vec_t;

  vec_t   tbl [17];
  entry_t q[$];
  logic   m_ovf;
  logic [7:0] m_drop;
  bit     chk_small;
  int     n_cmp;
  int     n_bad;

  function automatic logic [54:0] got_bus();
    return {tr_valid, tr_addr, tr_op, tr_ts, level, ovf, drop_cnt};
  endfunction

  task automatic compare(input string tag, input logic [54:0] want);
    logic [54:0] got;
    got = got_bus();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got v=%0b a=%h op=%h ts=%h lvl=%0d ovf=%0b drop=%0d, want v=%0b a=%h op=%h ts=%h lvl=%0d ovf=%0b drop=%0d",
               tag, got[54], got[53:38], got[37:30], got[29:14], got[13:9], got[8], got[7:0],
               want[54], want[53:38], want[37:30], want[29:14], want[13:9], want[8], want[7:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    entry_t h;
    logic   v;
    v = (q.size() != 0);
    h = '{ts: 16'h0, addr: 16'h0, op: 8'h0};
    if (v) h = q[0];
    compare(tag, {v, h.addr, h.op, h.ts, 5'(q.size()), m_ovf, m_drop});
    if (chk_small) begin
      n_cmp++;
      if (s_valid !== v || s_ts !== h.ts[3:0]) begin
        n_bad++;
        $display("FAIL %s_small: got v=%0b ts=%h, want v=%0b ts=%h", tag, s_valid, s_ts, v, h.ts[3:0]);
      end
    end
  endtask

  // One clock with bench-side queue model; ok=0 marks a fetch the filter should reject.
  task automatic cyc(input logic s, input logic [15:0] aa, input logic [7:0] dd,
                     input logic rdy, input logic ok, input string tag);
    entry_t e;
    bit     pop;
    bit     was_full;
    sync = s; a = aa; d = dd; tr_ready = rdy; clr = 1'b0;
    pop      = rdy && (q.size() != 0);
    was_full = (q.size() == DEPTH);
    e = '{ts: tb_ts, addr: aa, op: dd};
    step();
    if (pop) void'(q.pop_front());
    if (s && ok) begin
      if (!was_full || pop) q.push_back(e);
      else begin
        m_ovf = 1'b1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
    end
    check_model(tag);
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1; sync = 1'b1; tr_ready = 1'b1; a = 16'h1234; d = 8'h55;
    step();
    clr = 1'b0; sync = 1'b0; tr_ready = 1'b0;
    q.delete();
    m_ovf  = 1'b0;
    m_drop = 8'h00;
    compare(tag, {1'b0, 16'h0, 8'h0, 16'h0, 5'd0, 1'b0, 8'h00});
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_small = 1'b0;
    m_ovf = 1'b0; m_drop = 8'h00;
    rst = 1'b1; a = '0; d = '0; sync = 1'b0; clr = 1'b0; tr_ready = 1'b0;
`ifdef K6502_TRACE_FILTER_EN
    flt_lo = 16'h0000; flt_hi = 16'hFFFF; flt_inv = 1'b0;
`endif

    //            s  a         d      rdy  c     v  ea        eo     et      lvl    ovf   drop
    tbl[0]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'd0,  5'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'd0,  5'd0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 16'hE000, 8'hA9, 1'b0, 1'b0, 1'b1, 16'hE000, 8'hA9, 16'd2,  5'd1, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 16'hE002, 8'h8D, 1'b0, 1'b0, 1'b1, 16'hE000, 8'hA9, 16'd2,  5'd2, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 16'hE005, 8'h4C, 1'b0, 1'b0, 1'b1, 16'hE000, 8'hA9, 16'd2,  5'd3, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 16'hE010, 8'hEA, 1'b0, 1'b0, 1'b1, 16'hE000, 8'hA9, 16'd2,  5'd4, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 16'hE011, 8'h60, 1'b0, 1'b0, 1'b1, 16'hE000, 8'hA9, 16'd2,  5'd5, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 16'hE000, 8'hA9, 16'd2,  5'd5, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'hE002, 8'h8D, 16'd3,  5'd4, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'hE005, 8'h4C, 16'd4,  5'd3, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'hE010, 8'hEA, 16'd5,  5'd2, 1'b0, 8'd0};
    tbl[11] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'hE011, 8'h60, 16'd6,  5'd1, 1'b0, 8'd0};
    tbl[12] = '{1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 16'd0,  5'd0, 1'b0, 8'd0};
    tbl[13] = '{1'b1, 16'hF000, 8'h00, 1'b1, 1'b0, 1'b1, 16'hF000, 8'h00, 16'd13, 5'd1, 1'b0, 8'd0};
    tbl[14] = '{1'b1, 16'hF001, 8'h01, 1'b1, 1'b0, 1'b1, 16'hF001, 8'h01, 16'd14, 5'd1, 1'b0, 8'd0};
    tbl[15] = '{1'b1, 16'hF002, 8'h02, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 16'd0,  5'd0, 1'b0, 8'd0};
    tbl[16] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'd0,  5'd0, 1'b0, 8'd0};

    step();
    compare("reset", {1'b0, 16'h0, 8'h0, 16'h0, 5'd0, 1'b0, 8'h00});
    step();
    rst = 1'b0;

    // T1/T2: latency, ordering, stall hold, empty push+pop, clr priority
    for (int i = 0; i < 17; i++) begin
      sync = tbl[i].s; a = tbl[i].a; d = tbl[i].d; tr_ready = tbl[i].rdy; clr = tbl[i].c;
      step();
      compare($sformatf("vec%0d", i),
              {tbl[i].v, tbl[i].ea, tbl[i].eo, tbl[i].et, tbl[i].lvl, tbl[i].eovf, tbl[i].edrop});
    end
    clr = 1'b0;

    // T3: overflow with consumer stalled
    for (int i = 0; i < DEPTH + 3; i++)
      cyc(1'b1, 16'hC000 + 16'(i), 8'(i + 8'h40), 1'b0, 1'b1, "ovf_fill");
    n_cmp++;
    if (level !== 5'd16 || ovf !== 1'b1 || drop_cnt !== 8'd3) begin
      n_bad++;
      $display("FAIL ovf_state: got lvl=%0d ovf=%0b drop=%0d, want lvl=16 ovf=1 drop=3", level, ovf, drop_cnt);
    end

    // T4: full FIFO with simultaneous push and pop
    cyc(1'b1, 16'hD00D, 8'hEE, 1'b1, 1'b1, "full_pushpop");
    n_cmp++;
    if (level !== 5'd16 || drop_cnt !== 8'd3) begin
      n_bad++;
      $display("FAIL full_pushpop_lvl: got lvl=%0d drop=%0d, want lvl=16 drop=3", level, drop_cnt);
    end
    for (int i = 0; i < DEPTH + 1; i++)
      cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, "drain");
    do_clr("clr_after_ovf");

    // T5: sustained push/pop through pointer and 4-bit timestamp wrap
    chk_small = 1'b1;
    cyc(1'b1, 16'h1000, 8'h00, 1'b0, 1'b1, "wrap_prime");
    for (int i = 1; i <= 40; i++)
      cyc(1'b1, 16'h1000 + 16'(i), 8'(i), 1'b1, 1'b1, "wrap");
    cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, "wrap_drain");
    cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, "wrap_empty");
    chk_small = 1'b0;

`ifdef K6502_TRACE_FILTER_EN
    // T6: inclusive address window, then inverted
    flt_lo = 16'h8000; flt_hi = 16'h80FF; flt_inv = 1'b0;
    cyc(1'b1, 16'h7FFF, 8'h11, 1'b0, 1'b0, "flt_7fff");
    cyc(1'b1, 16'h8000, 8'h22, 1'b0, 1'b1, "flt_8000");
    cyc(1'b1, 16'h80FF, 8'h33, 1'b0, 1'b1, "flt_80ff");
    cyc(1'b1, 16'h8100, 8'h44, 1'b0, 1'b0, "flt_8100");
    n_cmp++;
    if (level !== 5'd2 || tr_addr !== 16'h8000 || drop_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL flt_window: got lvl=%0d a=%h drop=%0d, want lvl=2 a=8000 drop=0", level, tr_addr, drop_cnt);
    end
    do_clr("flt_clr");
    flt_inv = 1'b1;
    cyc(1'b1, 16'h7FFF, 8'h11, 1'b0, 1'b1, "flti_7fff");
    cyc(1'b1, 16'h8000, 8'h22, 1'b0, 1'b0, "flti_8000");
    cyc(1'b1, 16'h80FF, 8'h33, 1'b0, 1'b0, "flti_80ff");
    cyc(1'b1, 16'h8100, 8'h44, 1'b0, 1'b1, "flti_8100");
    cyc(1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, "flti_pop");
    n_cmp++;
    if (level !== 5'd1 || tr_addr !== 16'h8100) begin
      n_bad++;
      $display("FAIL flt_inv: got lvl=%0d a=%h, want lvl=1 a=8100", level, tr_addr);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
